// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: tracks E/M/W destinations, drives D-stage stall and D/E forwarding selects.
// Latency: stall and forwarding selects are combinational from the scoreboard and the current D inputs.
// Backpressure: stall freezes PC and F/D and turns the instruction entering E into a bubble until the conflict clears.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   d_rs, d_rt              D-stage source register indices
//   d_tuse_rs, d_tuse_rt    cycles until each source is consumed (3 = unused)
//   d_a3, d_tnew            D-stage destination (0 = no write), cycles until result ready
//   d_md, d_md_div          D instr uses MDU / is div-divu (HAZARD_MDU_EN builds only)
//   stall                   freeze front end, bubble into E
//   fwd_rs_d, fwd_rt_d      D source select: 00 RF, 01 E, 10 M, 11 W
//   fwd_rs_e, fwd_rt_e      E source select: 00 D/E reg, 10 M, 11 W
//
// Build option: define HAZARD_MDU_EN to add the MDU busy counter and its stall term.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [1:0]        d_tnew,
  input  logic              d_md,
  input  logic              d_md_div,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e
);

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [1:0]        tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } e_ent_t;

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [1:0]        tnew;
  } m_ent_t;

  e_ent_t            r_e;
  m_ent_t            r_m;
  // W results are always ready (tnew never exceeds 3 at D), so only the index is kept.
  logic [REG_AW-1:0] r_w_a3;
  logic              w_reg_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $0 is hard-wired zero: it never matches, so it is never stalled on or forwarded.
  function automatic logic hit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] a3);
    return (r != '0) && (a3 == r);
  endfunction

  function automatic logic conflict(input logic [REG_AW-1:0] r, input logic [1:0] tuse,
                                    input e_ent_t e, input m_ent_t m);
    return (hit(r, e.a3) && (tuse < e.tnew)) || (hit(r, m.a3) && (tuse < m.tnew));
  endfunction

  // Nearest producer wins even when not yet ready: falling through to an older
  // stage would hand over a stale value. The stall logic covers the not-ready case.
  function automatic logic [1:0] sel_d(input logic [REG_AW-1:0] r, input e_ent_t e,
                                       input m_ent_t m, input logic [REG_AW-1:0] w_a3);
    logic [1:0] s;
    s = 2'b00;
    if (hit(r, e.a3))      s = (e.tnew == 2'd0) ? 2'b01 : 2'b00;
    else if (hit(r, m.a3)) s = (m.tnew == 2'd0) ? 2'b10 : 2'b00;
    else if (hit(r, w_a3)) s = 2'b11;
    return s;
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] r, input m_ent_t m,
                                       input logic [REG_AW-1:0] w_a3);
    logic [1:0] s;
    s = 2'b00;
    if (hit(r, m.a3))      s = (m.tnew == 2'd0) ? 2'b10 : 2'b00;
    else if (hit(r, w_a3)) s = 2'b11;
    return s;
  endfunction

  assign w_reg_stall = conflict(d_rs, d_tuse_rs, r_e, r_m) | conflict(d_rt, d_tuse_rt, r_e, r_m);

  assign fwd_rs_d = sel_d(d_rs, r_e, r_m, r_w_a3);
  assign fwd_rt_d = sel_d(d_rt, r_e, r_m, r_w_a3);
  assign fwd_rs_e = sel_e(r_e.rs, r_m, r_w_a3);
  assign fwd_rt_e = sel_e(r_e.rt, r_m, r_w_a3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e    <= '0;
      r_m    <= '0;
      r_w_a3 <= '0;
    end else begin
      r_w_a3   <= r_m.a3;
      r_m.a3   <= r_e.a3;
      r_m.tnew <= sat_dec(r_e.tnew);
      if (stall) begin
        r_e <= '0;
      end else begin
        r_e.a3   <= d_a3;
        r_e.tnew <= sat_dec(d_tnew);
        r_e.rs   <= d_rs;
        r_e.rt   <= d_rt;
      end
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] r_mdu_cnt;
  logic          w_mdu_start;

  // mult/multu/div/divu write no GPR, while mfhi/mflo do; a d_md instruction with
  // no GPR destination is taken as an MDU start. mthi/mtlo also match, which only
  // costs a conservative busy window.
  assign w_mdu_start = d_md && !stall && (d_a3 == '0);
  assign stall       = w_reg_stall | (d_md && (r_mdu_cnt != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdu_cnt <= '0;
    end else if (w_mdu_start) begin
      r_mdu_cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_mdu_cnt != '0) begin
      r_mdu_cnt <= r_mdu_cnt - CW'(1);
    end
  end
`else
  logic w_unused_md;
  assign w_unused_md = d_md ^ d_md_div;
  assign stall       = w_reg_stall;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset/MDU sequences, random vs. model.
// Latency: outputs sampled 1 time unit after the falling edge, inputs driven on the falling edge.
// Backpressure: the model converts a stalled D instruction into an E bubble, as the pipeline does.
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md, d_md_div;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(5), .MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew), .d_md(d_md), .d_md_div(d_md_div),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md, div;
  } din_t;

  typedef struct {
    din_t       d;
    logic       st;
    logic [1:0] frs_d, frt_d, frs_e, frt_e;
  } vec_t;

  // ---------------- reference model: instructions indexed by stages past D ----------------
  int p_a3[1:3], p_tn[1:3], p_rs[1:3], p_rt[1:3];
  int cyc, busy_last;
  int m_stall, m_frs_d, m_frt_d, m_frs_e, m_frt_e;

  function automatic int remain(int age);
    return (p_tn[age] > age) ? p_tn[age] - age : 0;
  endfunction

  // Youngest producer of r decides; its select code equals its distance from D.
  function automatic int model_fwd(int r, int first_age);
    if (r == 0) return 0;
    for (int age = first_age; age <= 3; age++)
      if (p_a3[age] == r) return (remain(age) == 0) ? age : 0;
    return 0;
  endfunction

  function automatic int needs_wait(int r, int tuse);
    if (r == 0) return 0;
    for (int age = 1; age <= 2; age++)
      if (p_a3[age] == r && tuse < remain(age)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int a = 1; a <= 3; a++) begin
      p_a3[a] = 0; p_tn[a] = 0; p_rs[a] = 0; p_rt[a] = 0;
    end
    busy_last = -1;
  endtask

  task automatic model_eval();
    m_stall = needs_wait(d_rs, d_tuse_rs) | needs_wait(d_rt, d_tuse_rt);
`ifdef HAZARD_MDU_EN
    if (d_md && cyc <= busy_last) m_stall = 1;
`endif
    m_frs_d = model_fwd(d_rs, 1);
    m_frt_d = model_fwd(d_rt, 1);
    m_frs_e = model_fwd(p_rs[1], 2);
    m_frt_e = model_fwd(p_rt[1], 2);
  endtask

  task automatic model_advance();
    for (int a = 3; a >= 2; a--) begin
      p_a3[a] = p_a3[a-1]; p_tn[a] = p_tn[a-1]; p_rs[a] = p_rs[a-1]; p_rt[a] = p_rt[a-1];
    end
    if (m_stall != 0) begin
      p_a3[1] = 0; p_tn[1] = 0; p_rs[1] = 0; p_rt[1] = 0;
    end else begin
      p_a3[1] = d_a3; p_tn[1] = d_tnew; p_rs[1] = d_rs; p_rt[1] = d_rt;
`ifdef HAZARD_MDU_EN
      if (d_md && d_a3 == 0) busy_last = cyc + (d_md_div ? DIV_N : MULT_N);
`endif
    end
    cyc++;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic din_t mk(int rs, int rt, int tur, int tut, int a3, int tn, int md = 0, int dv = 0);
    din_t d;
    d.rs = 5'(rs); d.rt = 5'(rt); d.tu_rs = 2'(tur); d.tu_rt = 2'(tut);
    d.a3 = 5'(a3); d.tnew = 2'(tn); d.md = 1'(md); d.div = 1'(dv);
    return d;
  endfunction

  function automatic vec_t vv(din_t d, int st, int f0, int f1, int f2, int f3);
    vec_t v;
    v.d = d; v.st = 1'(st);
    v.frs_d = 2'(f0); v.frt_d = 2'(f1); v.frs_e = 2'(f2); v.frt_e = 2'(f3);
    return v;
  endfunction

  task automatic drive(input din_t d);
    d_rs = d.rs; d_rt = d.rt; d_tuse_rs = d.tu_rs; d_tuse_rt = d.tu_rt;
    d_a3 = d.a3; d_tnew = d.tnew; d_md = d.md; d_md_div = d.div;
  endtask

  task automatic tick(input din_t d);
    @(negedge clk);
    drive(d);
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_advance();
  endtask

  task automatic chk_all(input string tag, input int st, input int f0, input int f1,
                         input int f2, input int f3);
    chk({tag, "_stall"}, stall, st);
    chk({tag, "_fwd_rs_d"}, fwd_rs_d, f0);
    chk({tag, "_fwd_rt_d"}, fwd_rt_d, f1);
    chk({tag, "_fwd_rs_e"}, fwd_rs_e, f2);
    chk({tag, "_fwd_rt_e"}, fwd_rt_e, f3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(0, 0, 3, 3, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Counts stalled cycles of a waiting MDU reader, bounded so the bench cannot hang.
  task automatic count_md_stall(input string tag, input int exp_n);
    int n;
    n = 0;
    for (int k = 0; k < 3 * DIV_N; k++) begin
      tick(mk(0, 0, 3, 3, 8, 2, 1, 0));
      if (!stall) break;
      n++;
      advance();
    end
    chk(tag, n, exp_n);
    advance();
  endtask

  vec_t tbl[$];
  din_t nop;

  initial begin
    nop = mk(0, 0, 3, 3, 0, 0);
    // rs, rt, tuse_rs, tuse_rt, a3, tnew | stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e
    tbl.push_back(vv(mk(29, 0, 1, 3, 1, 3), 0, 0, 0, 0, 0)); // lw $1
    tbl.push_back(vv(mk(1, 3, 1, 1, 2, 2), 1, 0, 0, 0, 0));  // addu $2,$1,$3: load-use
    tbl.push_back(vv(mk(1, 3, 1, 1, 2, 2), 0, 0, 0, 0, 0));  // released after one cycle
    tbl.push_back(vv(mk(5, 0, 1, 3, 0, 2), 0, 0, 0, 3, 0));  // ori $0; addu in E takes W
    tbl.push_back(vv(mk(0, 0, 1, 1, 2, 2), 0, 0, 0, 0, 0));  // addu $2,$0,$0
    tbl.push_back(vv(mk(2, 0, 1, 3, 1, 3), 0, 0, 0, 0, 0));  // lw $1,($2)
    tbl.push_back(vv(mk(1, 0, 0, 0, 0, 0), 1, 0, 0, 2, 0));  // beq $1,$0; lw in E uses M
    tbl.push_back(vv(mk(1, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0));  // second stall cycle
    tbl.push_back(vv(mk(1, 0, 0, 0, 0, 0), 0, 3, 0, 0, 0));  // beq takes W
    tbl.push_back(vv(mk(4, 5, 1, 1, 1, 2), 0, 0, 0, 0, 0));  // addu $1
    tbl.push_back(vv(mk(6, 7, 1, 1, 1, 2), 0, 0, 0, 0, 0));  // addu $1
    tbl.push_back(vv(mk(1, 1, 1, 1, 4, 2), 0, 0, 0, 0, 0));  // subu $4,$1,$1
    tbl.push_back(vv(nop, 0, 0, 0, 2, 2));                   // subu in E: newest from M
    tbl.push_back(vv(mk(0, 0, 3, 3, 31, 1), 0, 0, 0, 0, 0)); // jal
    tbl.push_back(vv(mk(31, 4, 0, 3, 0, 0), 0, 1, 3, 0, 0)); // jr $31 from E, rt $4 from W
    tbl.push_back(vv(mk(31, 0, 1, 1, 5, 2), 0, 2, 0, 2, 0)); // addu $5,$31
    tbl.push_back(vv(mk(0, 0, 3, 3, 7, 3), 0, 0, 0, 3, 0));  // lw $7
    tbl.push_back(vv(mk(7, 7, 2, 3, 0, 0), 0, 0, 0, 0, 0));  // tuse 2 / 3 never stall
    tbl.push_back(vv(nop, 0, 0, 0, 0, 0));                   // M producer not ready: no W fallthrough
    tbl.push_back(vv(mk(0, 0, 3, 3, 3, 3), 0, 0, 0, 0, 0));  // lw $3
    tbl.push_back(vv(mk(0, 3, 3, 1, 0, 0), 1, 0, 0, 0, 0));  // rt load-use
    tbl.push_back(vv(mk(0, 3, 3, 1, 0, 0), 0, 0, 0, 0, 0));
    tbl.push_back(vv(nop, 0, 0, 0, 0, 3));

    cyc = 0;
    model_reset();
    drive(mk(1, 1, 0, 0, 1, 3));
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    do_reset();

    foreach (tbl[i]) begin
      tick(tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].frs_d, tbl[i].frt_d,
              tbl[i].frs_e, tbl[i].frt_e);
      advance();
    end

    // Asynchronous reset while a load-use stall is active.
    do_reset();
    tick(mk(29, 0, 1, 3, 1, 3));
    advance();
    tick(mk(1, 1, 1, 1, 2, 2));
    chk("midrst_pre_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

`ifdef HAZARD_MDU_EN
    do_reset();
    tick(mk(0, 0, 1, 1, 0, 0, 1, 1));   // div
    chk("div_issue_stall", stall, 0);
    advance();
    count_md_stall("div_mflo_stall_cycles", DIV_N);
    tick(mk(0, 0, 1, 1, 0, 0, 1, 0));   // mult
    advance();
    count_md_stall("mult_mflo_stall_cycles", MULT_N);
    tick(mk(0, 0, 1, 1, 0, 0, 1, 1));   // div, then reset mid-operation
    advance();
    tick(mk(0, 0, 3, 3, 8, 2, 1, 0));
    chk("mdu_busy_stall", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mdu_reset_clears", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
`endif

    // Random instruction stream against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      din_t d;
      d = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
`ifdef HAZARD_MDU_EN
      if ($urandom_range(0, 9) == 0) begin
        d.md  = 1'b1;
        d.div = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) d.a3 = 5'd0;
      end
`endif
      tick(d);
      chk_all($sformatf("rnd%0d", n), m_stall, m_frs_d, m_frt_d, m_frs_e, m_frt_e);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
